// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch stage and the decoder
package cpu_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam int          OP_W      = 6;
   typedef enum logic [1:0] {FETCH, FULL, DISCARD} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc} holding buffer used while IF/ID is stalled
module fetch_skid_buf (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        unload_i,
   input  logic        clear_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic        full_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);
   logic        full_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;

   // clear beats load, load beats unload; payload only written on load
   always_ff @(posedge clk_i) begin
      if (!rst_i || clear_i) full_q <= 1'b0;
      else if (load_i) full_q <= 1'b1;
      else if (unload_i) full_q <= 1'b0;
      if (rst_i && !clear_i && load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, imem req/ack fetcher and IF/ID output register
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_o,
   output logic [31:0]     imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_data_i,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [31:0]     redirect_pc_i,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [OP_W-1:0] op_o,
   output logic [31:0]     pc_o,
   output logic [31:0]     pc_plus4_o
);
   fetch_state_e state_q;
   logic [31:0]  fetch_pc_q, addr_q, instr_q, pc_q;
   logic         req_q, valid_q;
   logic         ack, take, adv, skid_load, skid_unload, skid_full;
   logic [31:0]  skid_instr, skid_pc, redir_pc, fetch_pc_d;
   logic         unused_bits;

   assign ack         = imem_ack_i && req_q;
   assign redir_pc    = {redirect_pc_i[31:2], 2'b00};
   assign unused_bits = ^redirect_pc_i[1:0];

   // output advances when empty or unstalled; an ack in FETCH is real data, in DISCARD it is dropped
   always_comb begin
      take        = ack && state_q == FETCH;
      adv         = !valid_q || !stall_i;
      skid_load   = !redirect_i && take && !adv;
      skid_unload = !redirect_i && adv && skid_full;
      fetch_pc_d  = fetch_pc_q + PC_STEP;
   end

   fetch_skid_buf u_skid (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (redirect_i),
      .instr_i  (imem_data_i),
      .pc_i     (addr_q),
      .full_o   (skid_full),
      .instr_o  (skid_instr),
      .pc_o     (skid_pc)
   );

   // fetch FSM with registered request and IF/ID outputs; redirect overrides stall and ack
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= FETCH;
         fetch_pc_q <= {RESET_PC[31:2], 2'b00};
         addr_q     <= {RESET_PC[31:2], 2'b00};
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
      end else if (redirect_i) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         fetch_pc_q <= redir_pc;
         req_q      <= 1'b1;
         state_q    <= (req_q && !ack) ? DISCARD : FETCH;
         if (!(req_q && !ack)) addr_q <= redir_pc;
      end else begin
         if (adv) begin
            valid_q <= skid_full || take;
            instr_q <= skid_full ? skid_instr : take ? imem_data_i : NOP_INSTR;
            pc_q    <= skid_full ? skid_pc : take ? addr_q : pc_q;
         end
         case (state_q)
            FETCH: begin
               req_q <= !(take && !adv);
               if (take) begin
                  fetch_pc_q <= fetch_pc_d;
                  addr_q     <= fetch_pc_d;
                  if (!adv) state_q <= FULL;
               end
            end
            FULL: if (adv) begin
               state_q <= FETCH;
               req_q   <= 1'b1;
            end
            DISCARD: if (ack) begin
               state_q <= FETCH;
               addr_q  <= fetch_pc_q;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign imem_req_o    = req_q;
   assign imem_addr_o   = addr_q;
   assign instr_valid_o = valid_q;
   assign instr_o       = instr_q;
   assign op_o          = instr_q[31:32-OP_W];
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_q + PC_STEP;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of the fetch stage against an address-echo memory
module tb_instr_fetch_unit;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_data_i = 32'h0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [5:0]  op_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   int          checks = 0;
   int          errors = 0;
   int          wait_n = 0;
   int          wcnt = 0;

   instr_fetch_unit dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_data_i   (imem_data_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .op_o          (op_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o)
   );

   always #5 clk_i = ~clk_i;

   // memory returns the address as data after wait_n extra cycles
   initial begin
      forever begin
         @(negedge clk_i);
         #1;
         if (imem_req_o === 1'b1) begin
            if (wcnt >= wait_n) begin
               imem_ack_i  = 1'b1;
               imem_data_i = imem_addr_o;
               wcnt        = 0;
            end else begin
               imem_ack_i = 1'b0;
               wcnt++;
            end
         end else begin
            imem_ack_i = 1'b0;
            wcnt       = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic do_reset(input int w);
      rst_i      = 1'b0;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      wait_n     = w;
      step(1);
      chk("rst_req", imem_req_o, 0);
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", pc_o, 0);
      step(1);
      rst_i = 1'b1;
   endtask

   initial begin
      // 0-wait streaming, then a 3-cycle stall at pc 8
      do_reset(0);
      step(1);
      chk("a_req", imem_req_o, 1);
      chk("a_addr", imem_addr_o, 0);
      chk("a_valid0", instr_valid_o, 0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("a_valid", instr_valid_o, 1);
         chk("a_pc", pc_o, 4 * i);
         chk("a_instr", instr_o, 4 * i);
         chk("a_pc4", pc_plus4_o, 4 * i + 4);
      end
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("s_hold_pc", pc_o, 8);
         chk("s_req", imem_req_o, 0);
      end
      stall_i = 1'b0;
      step(1);
      chk("s_pc12", pc_o, 12);
      chk("s_valid12", instr_valid_o, 1);
      step(1);
      chk("s_pc16", pc_o, 16);
      chk("s_valid16", instr_valid_o, 1);

      // 2-wait memory
      do_reset(2);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("b_addr0", imem_addr_o, 0);
         chk("b_valid0", instr_valid_o, 0);
      end
      step(1);
      chk("b_pc0", pc_o, 0);
      chk("b_v0", instr_valid_o, 1);
      chk("b_addr4", imem_addr_o, 4);
      step(2);
      chk("b_addr4_hold", imem_addr_o, 4);
      step(1);
      chk("b_pc4", pc_o, 4);
      chk("b_v4", instr_valid_o, 1);

      // redirect during an outstanding 3-wait fetch at 0x20
      do_reset(0);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h1C;
      step(1);
      redirect_i = 1'b0;
      chk("c_addr1c", imem_addr_o, 32'h1C);
      step(1);
      chk("c_pc1c", pc_o, 32'h1C);
      wait_n  = 3;
      stall_i = 1'b1;
      step(1);
      chk("c_addr20", imem_addr_o, 32'h20);
      chk("c_hold1c", pc_o, 32'h1C);
      chk("c_hold_v", instr_valid_o, 1);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h43;
      step(1);
      redirect_i = 1'b0;
      stall_i    = 1'b0;
      chk("c_flush_v", instr_valid_o, 0);
      chk("c_flush_i", instr_o, 0);
      chk("c_old_addr", imem_addr_o, 32'h20);
      chk("c_req", imem_req_o, 1);
      step(1);
      chk("c_old_addr2", imem_addr_o, 32'h20);
      step(1);
      chk("c_addr40", imem_addr_o, 32'h40);
      chk("c_drop_v", instr_valid_o, 0);
      step(3);
      chk("c_wait_v", instr_valid_o, 0);
      step(1);
      chk("c_v40", instr_valid_o, 1);
      chk("c_pc40", pc_o, 32'h40);
      chk("c_op40", op_o, 0);

      // redirect, stall and ack in the same cycle
      do_reset(0);
      step(2);
      chk("d_pc0", pc_o, 0);
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      step(1);
      redirect_i = 1'b0;
      chk("d_valid", instr_valid_o, 0);
      chk("d_instr", instr_o, 0);
      chk("d_addr", imem_addr_o, 32'h100);
      step(1);
      chk("d_fill_v", instr_valid_o, 1);
      chk("d_fill_pc", pc_o, 32'h100);
      step(1);
      chk("d_hold_pc", pc_o, 32'h100);
      chk("d_full_req", imem_req_o, 0);
      stall_i = 1'b0;
      step(1);
      chk("d_pc104", pc_o, 32'h104);

      // wrap at the top of the address space
      do_reset(0);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFF;
      step(1);
      redirect_i = 1'b0;
      chk("e_addr", imem_addr_o, 32'hFFFF_FFFC);
      step(1);
      chk("e_pc", pc_o, 32'hFFFF_FFFC);
      chk("e_pc4", pc_plus4_o, 0);
      chk("e_op", op_o, 6'h3F);
      chk("e_next_addr", imem_addr_o, 0);
      step(1);
      chk("e_pc0", pc_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
